// File: rtl/mult_if.sv
`default_nettype none
// ============================================================================
// Module   : mult_if
// Brief    : Operand / result / handshake bundle for mult_pipeline_top.
//            The master drives start and operands; the slave (multiplier)
//            returns busy, the finish pulse and the 2*WIDTH product.
// Revision : 1.0 - initial release
// ============================================================================
interface mult_if #(
    parameter int WIDTH = 64
);
    logic                 start_i;
    logic                 busy_o;
    logic                 finish_o;
    logic [WIDTH-1:0]     indata_a_i;
    logic [WIDTH-1:0]     indata_b_i;
    logic [2*WIDTH-1:0]   outdata_r_o;

    modport master (
        output start_i,
        output indata_a_i,
        output indata_b_i,
        input  busy_o,
        input  finish_o,
        input  outdata_r_o
    );

    modport slave (
        input  start_i,
        input  indata_a_i,
        input  indata_b_i,
        output busy_o,
        output finish_o,
        output outdata_r_o
    );
endinterface
`default_nettype wire

// File: rtl/mult_pipeline_top.sv
`default_nettype none
// ============================================================================
// Module   : mult_pipeline_top
// Brief    : Fully pipelined unsigned WIDTH x WIDTH -> 2*WIDTH multiplier.
//            B is split into NUM_MULS chunks; each stage adds one shifted
//            partial product into an accumulator travelling with A and B.
//            Fixed latency NUM_MULS+2, one new operand pair per cycle.
//            NUM_MULS must divide WIDTH.
// Revision : 1.0 - initial release
// ============================================================================
module mult_pipeline_top #(
    parameter int NUM_MULS = 4,
    parameter int WIDTH    = 64
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    mult_if.slave  bus
);
    localparam int CHUNK_W = WIDTH / NUM_MULS;
    localparam int RES_W   = 2 * WIDTH;

    // Operand copies: index 0 is the input register, index k feeds stage k+1.
    logic [WIDTH-1:0] a_q     [0:NUM_MULS-1];
    logic [WIDTH-1:0] b_q     [0:NUM_MULS-1];
    // Running accumulator after stage k (1..NUM_MULS).
    logic [RES_W-1:0] acc_q   [1:NUM_MULS];
    // Shifted partial product contributed by stage k.
    logic [RES_W-1:0] partial [1:NUM_MULS];

    // Valid delay line: bit 0 is stage 0, bit NUM_MULS is the last
    // accumulate stage; finish_q is the final (output) stage.
    logic [NUM_MULS:0] valid_q;
    logic              finish_q;
    logic [RES_W-1:0]  result_q;

    // Partial product of A with the (k-1)-th chunk of B, aligned to its weight.
    for (genvar k = 1; k <= NUM_MULS; k++) begin : g_partial
        assign partial[k] = (RES_W'(a_q[k-1]) * RES_W'(b_q[k-1][(k-1)*CHUNK_W +: CHUNK_W]))
                            << ((k-1)*CHUNK_W);
    end

    // Datapath registers: operand capture, operand carry and accumulation.
    // Captured every cycle; stale data is harmless because valid gates use.
    always_ff @(posedge clk_i) begin
        a_q[0]   <= bus.indata_a_i;
        b_q[0]   <= bus.indata_b_i;
        acc_q[1] <= partial[1];
        for (int k = 2; k <= NUM_MULS; k++) begin
            acc_q[k] <= acc_q[k-1] + partial[k];
        end
        for (int k = 1; k < NUM_MULS; k++) begin
            a_q[k] <= a_q[k-1];
            b_q[k] <= b_q[k-1];
        end
    end

    // Control path: valid shift register, finish pulse and held result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q  <= '0;
            finish_q <= 1'b0;
            result_q <= '0;
        end else begin
            valid_q  <= {valid_q[NUM_MULS-1:0], bus.start_i};
            finish_q <= valid_q[NUM_MULS];
            if (valid_q[NUM_MULS]) begin
                result_q <= acc_q[NUM_MULS];
            end
        end
    end

    // Busy covers every stage before the output register, so it drops in
    // the finish cycle of the last operation in flight.
    assign bus.busy_o      = |valid_q;
    assign bus.finish_o    = finish_q;
    assign bus.outdata_r_o = result_q;
endmodule
`default_nettype wire

// File: tb/tb_mult_pipeline_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_pipeline_top
// Brief    : Self-checking bench for mult_pipeline_top. A queue-based model
//            predicts finish/busy/product every cycle; directed cases pin
//            literal products and latencies; a random burst follows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_pipeline_top;
    localparam int W  = 64;
    localparam int NM = 4;
    localparam int L  = NM + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mult_if #(.WIDTH(W)) bus ();

    mult_pipeline_top #(.NUM_MULS(NM), .WIDTH(W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int           s;     // posedge number that samples the start
        logic [127:0] prod;
    } op_t;

    op_t          inflight [$];
    logic [127:0] last_out = '0;
    int           cyc      = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    task automatic drive(input logic s, input logic [63:0] a, input logic [63:0] b);
        @(posedge clk);
        #1;
        bus.start_i    = s;
        bus.indata_a_i = a;
        bus.indata_b_i = b;
    endtask

    // Reference model and per-cycle compare, run on the falling edge.
    initial begin
        forever begin
            logic         exp_fin;
            logic         exp_busy;
            logic [127:0] exp_prod;
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                inflight.delete();
                last_out = '0;
                chk("model_rst_finish", {127'd0, bus.finish_o}, 128'd0);
                chk("model_rst_busy", {127'd0, bus.busy_o}, 128'd0);
                chk("model_rst_out", bus.outdata_r_o, 128'd0);
            end else begin
                exp_fin  = 1'b0;
                exp_busy = 1'b0;
                exp_prod = '0;
                foreach (inflight[i]) begin
                    if (inflight[i].s + L - 1 == cyc) begin
                        exp_fin  = 1'b1;
                        exp_prod = inflight[i].prod;
                    end else if (inflight[i].s <= cyc && cyc < inflight[i].s + L - 1) begin
                        exp_busy = 1'b1;
                    end
                end
                if (exp_fin) last_out = exp_prod;
                chk("model_finish", {127'd0, bus.finish_o}, {127'd0, exp_fin});
                chk("model_busy", {127'd0, bus.busy_o}, {127'd0, exp_busy});
                chk("model_out", bus.outdata_r_o, last_out);
                while (inflight.size() > 0 && inflight[0].s + L - 1 <= cyc) begin
                    void'(inflight.pop_front());
                end
                if (bus.start_i) begin
                    inflight.push_back('{s: cyc + 1,
                                         prod: 128'(bus.indata_a_i) * 128'(bus.indata_b_i)});
                end
            end
        end
    end

    // One start pulse; returns cycles from the sampling edge to finish.
    task automatic single_op(input logic [63:0] a, input logic [63:0] b,
                             output int lat, output logic [127:0] prod);
        drive(1'b1, a, b);
        drive(1'b0, r64(), r64());
        lat = 1;
        while (!bus.finish_o && lat < 4 * L) begin
            chk("busy_during_op", {127'd0, bus.busy_o}, 128'd1);
            @(posedge clk);
            #1;
            lat++;
        end
        prod = bus.outdata_r_o;
        chk("busy_at_finish", {127'd0, bus.busy_o}, 128'd0);
    endtask

    initial begin
        int           lat;
        int           n;
        int           nf;
        logic [127:0] prod;
        int           fcyc  [4];
        logic [127:0] fprod [4];
        logic [127:0] expb  [4];

        bus.start_i    = 1'b0;
        bus.indata_a_i = '0;
        bus.indata_b_i = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_finish", {127'd0, bus.finish_o}, 128'd0);
        chk("reset_busy", {127'd0, bus.busy_o}, 128'd0);
        chk("reset_out", bus.outdata_r_o, 128'd0);
        rst_n = 1'b1;

        // 3 * 5
        single_op(64'd3, 64'd5, lat, prod);
        chk("lat_3x5", 128'(lat), 128'(L));
        chk("prod_3x5", prod, 128'h0F);
        @(posedge clk);
        #1;
        chk("finish_single_pulse", {127'd0, bus.finish_o}, 128'd0);

        // All ones
        single_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, lat, prod);
        chk("lat_max", 128'(lat), 128'(L));
        chk("prod_max", prod, 128'hFFFFFFFFFFFFFFFE_0000000000000001);

        // Four back-to-back starts
        expb[0] = 128'd6;
        expb[1] = 128'h1_0000000000000000;
        expb[2] = 128'd0;
        expb[3] = 128'h1_23456789ABCDEF00;
        drive(1'b1, 64'd2, 64'd3);
        drive(1'b1, 64'h1_0000_0000, 64'h1_0000_0000);
        drive(1'b1, 64'd0, 64'hDEAD);
        drive(1'b1, 64'h1234_5678_9ABC_DEF0, 64'h10);
        drive(1'b0, r64(), r64());
        n  = 4;
        nf = 0;
        while (nf < 4 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.finish_o) begin
                fcyc[nf]  = n;
                fprod[nf] = bus.outdata_r_o;
                nf++;
            end
        end
        chk("burst_count", 128'(nf), 128'd4);
        for (int i = 0; i < nf; i++) begin
            chk("burst_prod", fprod[i], expb[i]);
            chk("burst_cycle", 128'(fcyc[i]), 128'(L + i));
        end

        // Idle cycles with toggling operands
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, r64(), r64());
            chk("idle_finish", {127'd0, bus.finish_o}, 128'd0);
        end
        chk("idle_out_held", bus.outdata_r_o, 128'h1_23456789ABCDEF00);

        // Reset in the middle of an operation
        drive(1'b1, 64'd7, 64'd9);
        drive(1'b0, r64(), r64());
        @(posedge clk);
        #1;
        chk("busy_before_reset", {127'd0, bus.busy_o}, 128'd1);
        chk("out_before_reset", bus.outdata_r_o, 128'h1_23456789ABCDEF00);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out", bus.outdata_r_o, 128'd0);
        chk("async_rst_busy", {127'd0, bus.busy_o}, 128'd0);
        chk("async_rst_finish", {127'd0, bus.finish_o}, 128'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, r64(), r64());
            chk("no_stale_finish", {127'd0, bus.finish_o}, 128'd0);
        end
        single_op(64'd7, 64'd9, lat, prod);
        chk("lat_after_reset", 128'(lat), 128'(L));
        chk("prod_after_reset", prod, 128'd63);

        // Random back-to-back stream, checked by the model every cycle
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 15))
                0:       drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, r64());
                1:       drive(1'b1, r64(), 64'd0);
                default: drive(1'b1, r64(), r64());
            endcase
        end
        repeat (L + 3) drive(1'b0, r64(), r64());
        chk("drain_busy", {127'd0, bus.busy_o}, 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
